elastic_buf: RTL and testbench
==============================

// Module: elastic_buf
// PURPOSE
//   Parametrised single-clock elastic buffer: WIDTH-bit words, DEPTH entries, valid/ready on both sides.
//   Generalises the plain enable-register stage: adds buffering, backpressure, sync flush, occupancy/high-water reporting.
//   Sits between producer/consumer stages in the same clock domain; feeds the CDC FIFO write side.
// PARAMETERS
//   WIDTH      8          data word width, >=1
//   DEPTH      4          number of entries; power of two, >=2
//   AF_THRESH  DEPTH-1    almost_full asserts when count >= AF_THRESH; legal range 1..DEPTH
// PORTS
//   clk        in   1                clock, all state on rising edge
//   rst_n      in   1                reset, asynchronous, active-low
//   clr        in   1                synchronous flush, priority over push/pop
//   in_valid   in   1                producer offers in_data
//   in_ready   out  1                buffer accepts; push = in_valid & in_ready
//   in_data    in   WIDTH            write word
//   out_valid  out  1                out_data holds oldest entry
//   out_ready  in   1                consumer takes; pop = out_valid & out_ready
//   out_data   out  WIDTH            oldest entry; 0 when empty after reset/clr
//   count      out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH
//   almost_full out 1                count >= AF_THRESH
//   hwm        out  $clog2(DEPTH)+1  max count since reset/clr, sticky
// BEHAVIOUR
//   Reset (rst_n=0, async): rd/wr pointers=0, count=0, hwm=0, storage=0; in_ready=1, out_valid=0, out_data=0,
//     almost_full=0 (AF_THRESH>=1). Reset mid-transfer discards all contents; no push/pop on the release edge effect.
//   in_ready = (count != DEPTH); depends on state only, never combinationally on out_ready.
//   out_valid = (count != 0); out_data = storage[rd_ptr], pure mux of flops, no extra register.
//   Latency: word pushed at edge N is on out_data with out_valid=1 after edge N (1 cycle, empty case).
//   Push: storage[wr_ptr] <= in_data; wr_ptr wraps DEPTH-1 -> 0 (natural binary wrap, DEPTH pow2).
//   Pop: rd_ptr wraps identically. Order strictly FIFO.
//   count_next = count + push - pop. Simultaneous push&pop: count unchanged, both pointers advance.
//   Full (count=DEPTH): in_ready=0, push impossible even if pop same cycle (no pass-through); pop proceeds.
//   Empty (count=0): out_valid=0, pop impossible; push proceeds. in_valid while full: word held by producer, no loss.
//   hwm <= max(hwm, count_next) each cycle; never decreases except on reset/clr.
//   clr=1: pointers, count, hwm -> 0 next edge; push/pop that cycle ignored; storage contents untouched
//     except out_data forced to read 0: storage[0] cleared on clr.
//   almost_full combinational from count. No error flags: protocol prevents over/underflow.
//   Producer must hold in_data/in_valid until accepted; consumer may drop out_ready freely.
// TESTING
//   1 reset: rst_n=0 mid-stream with count=3 -> count=0, out_valid=0, out_data=0, in_ready=1, hwm=0 immediately.
//   2 fill/drain: WIDTH=8 DEPTH=4, push 0x11,0x22,0x33,0x44 with out_ready=0 -> count=4, in_ready=0, almost_full=1
//       at count=3; then out_ready=1 -> pops 0x11..0x44 in order, count 3,2,1,0, hwm stays 4.
//   3 full + push&pop: at count=4 drive in_valid=1 (0x55) and out_ready=1 -> pop 0x11 only, count=3;
//       next cycle 0x55 accepted, count=4, later popped 5th.
//   4 steady stream: in_valid=out_ready=1 for 20 cycles, incrementing data from 0x00 -> after 1-cycle fill,
//       count stays 1, out_data sequence 0x00..0x13 unbroken, pointers wrap 5 times, hwm=1.
//   5 clr: count=2 with hwm=3, assert clr with in_valid=1 and out_ready=1 -> next edge count=0, hwm=0,
//       out_valid=0, out_data=0, nothing pushed or popped.
//   6 random: randomised valid/ready (50%) 1000 words vs scoreboard queue -> zero mismatches, count never >DEPTH,
//       in_ready/out_valid always match count; rerun with DEPTH=8, WIDTH=32, AF_THRESH=6.

Source files
------------

// File: rtl/elastic_buf_if.sv
// rtl/elastic_buf_if.sv - valid/ready stream pair for the elastic buffer
interface elastic_buf_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/elastic_buf.sv
// rtl/elastic_buf.sv - single-clock elastic FIFO buffer with flush, almost_full and high-water mark
module elastic_buf #(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 4,
  parameter int AF_THRESH = DEPTH - 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clr,
  elastic_buf_if.slave           bus,
  output logic [$clog2(DEPTH):0] count,
  output logic                   almost_full,
  output logic [$clog2(DEPTH):0] hwm
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count_next;
  logic             push;
  logic             pop;

  // in_ready is a function of occupancy only, so a full buffer never passes through
  assign bus.in_ready  = (count != CW'(DEPTH));
  assign bus.out_valid = (count != '0);
  assign bus.out_data  = mem[rd_ptr];
  assign almost_full   = (count >= CW'(AF_THRESH));

  assign push       = bus.in_valid & bus.in_ready;
  assign pop        = bus.out_valid & bus.out_ready;
  assign count_next = count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      hwm    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (clr) begin
      // Clearing entry 0 makes the empty out_data read back as zero after a flush
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      hwm    <= '0;
      mem[0] <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= bus.in_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      count <= count_next;
      if (count_next > hwm) begin
        hwm <= count_next;
      end
    end
  end
endmodule

// File: tb/tb_elastic_buf.sv
// tb/tb_elastic_buf.sv - self-checking bench for elastic_buf (DEPTH=4/WIDTH=8 and DEPTH=8/WIDTH=32)
module tb_elastic_buf;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       clr_a;
  logic       clr_b;
  logic [2:0] cnt_a;
  logic [2:0] hwm_a;
  logic       af_a;
  logic [3:0] cnt_b;
  logic [3:0] hwm_b;
  logic       af_b;

  elastic_buf_if #(.WIDTH(8))  ifa ();
  elastic_buf_if #(.WIDTH(32)) ifb ();

  elastic_buf #(.WIDTH(8), .DEPTH(4)) dut_a (
    .clk(clk), .rst_n(rst_n), .clr(clr_a), .bus(ifa.slave),
    .count(cnt_a), .almost_full(af_a), .hwm(hwm_a)
  );

  elastic_buf #(.WIDTH(32), .DEPTH(8), .AF_THRESH(6)) dut_b (
    .clk(clk), .rst_n(rst_n), .clr(clr_b), .bus(ifb.slave),
    .count(cnt_b), .almost_full(af_b), .hwm(hwm_b)
  );

  always #5 clk = ~clk;

  int          n_pass  = 0;
  int          n_total = 0;
  logic [31:0] qa[$];
  logic [31:0] qb[$];
  int          hwm_ma, hwm_mb;
  bit          fresh_a, fresh_b;
  bit          acc_a, acc_b;
  int          pushed_a, pushed_b;
  logic [7:0]  fill_v [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
  logic [7:0]  drain_v[4] = '{8'h22, 8'h33, 8'h44, 8'h55};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  task automatic check_a();
    chk("a_count", 32'(cnt_a), qa.size());
    chk("a_in_ready", 32'(ifa.in_ready), 32'(qa.size() != 4));
    chk("a_out_valid", 32'(ifa.out_valid), 32'(qa.size() != 0));
    chk("a_almost_full", 32'(af_a), 32'(qa.size() >= 3));
    chk("a_hwm", 32'(hwm_a), hwm_ma);
    if (qa.size() != 0) chk("a_out_data", 32'(ifa.out_data), qa[0]);
    else if (fresh_a) chk("a_out_data_zero", 32'(ifa.out_data), 32'h0);
  endtask

  task automatic check_b();
    chk("b_count", 32'(cnt_b), qb.size());
    chk("b_in_ready", 32'(ifb.in_ready), 32'(qb.size() != 8));
    chk("b_out_valid", 32'(ifb.out_valid), 32'(qb.size() != 0));
    chk("b_almost_full", 32'(af_b), 32'(qb.size() >= 6));
    chk("b_hwm", 32'(hwm_b), hwm_mb);
    if (qb.size() != 0) chk("b_out_data", ifb.out_data, qb[0]);
    else if (fresh_b) chk("b_out_data_zero", ifb.out_data, 32'h0);
  endtask

  // One clock: decide accept/take from the model, advance the edge, update the model, check both DUTs
  task automatic tick();
    bit          pop_a, pop_b;
    logic [31:0] da, db;
    acc_a = ifa.in_valid && qa.size() != 4;
    pop_a = ifa.out_ready && qa.size() != 0;
    da    = 32'(ifa.in_data);
    acc_b = ifb.in_valid && qb.size() != 8;
    pop_b = ifb.out_ready && qb.size() != 0;
    db    = ifb.in_data;
    @(posedge clk);
    #1;
    if (clr_a) begin
      qa.delete(); hwm_ma = 0; fresh_a = 1; acc_a = 0;
    end else begin
      if (pop_a) void'(qa.pop_front());
      if (acc_a) begin qa.push_back(da); fresh_a = 0; pushed_a++; end
      if (qa.size() > hwm_ma) hwm_ma = qa.size();
    end
    if (clr_b) begin
      qb.delete(); hwm_mb = 0; fresh_b = 1; acc_b = 0;
    end else begin
      if (pop_b) void'(qb.pop_front());
      if (acc_b) begin qb.push_back(db); fresh_b = 0; pushed_b++; end
      if (qb.size() > hwm_mb) hwm_mb = qb.size();
    end
    check_a();
    check_b();
  endtask

  task automatic set_a(input bit iv, input logic [7:0] d, input bit ordy);
    ifa.in_valid  = iv;
    ifa.in_data   = d;
    ifa.out_ready = ordy;
  endtask

  task automatic model_reset();
    qa.delete(); qb.delete();
    hwm_ma = 0; hwm_mb = 0;
    fresh_a = 1; fresh_b = 1;
  endtask

  initial begin
    rst_n = 1'b0;
    clr_a = 1'b0; clr_b = 1'b0;
    set_a(0, 8'h0, 0);
    ifb.in_valid = 1'b0; ifb.in_data = '0; ifb.out_ready = 1'b0;
    model_reset();
    #2;
    check_a(); check_b();
    #1 rst_n = 1'b1;

    // Fill with consumer stalled, then drain in order
    for (int i = 0; i < 4; i++) begin set_a(1, fill_v[i], 0); tick(); end
    set_a(0, 8'h0, 0);
    chk("fill_count", 32'(cnt_a), 32'd4);
    chk("fill_in_ready", 32'(ifa.in_ready), 32'd0);
    chk("fill_af", 32'(af_a), 32'd1);
    set_a(0, 8'h0, 1);
    for (int i = 0; i < 4; i++) begin
      chk("drain_word", 32'(ifa.out_data), 32'(fill_v[i]));
      tick();
    end
    chk("drain_hwm", 32'(hwm_a), 32'd4);

    // Full with push and pop offered: only the pop happens
    for (int i = 0; i < 4; i++) begin set_a(1, fill_v[i], 0); tick(); end
    set_a(1, 8'h55, 1); tick();
    chk("full_pp_count", 32'(cnt_a), 32'd3);
    set_a(1, 8'h55, 0); tick();
    chk("full_retry_count", 32'(cnt_a), 32'd4);
    set_a(0, 8'h0, 1);
    for (int i = 0; i < 4; i++) begin
      chk("full_drain_word", 32'(ifa.out_data), 32'(drain_v[i]));
      tick();
    end

    // Asynchronous reset mid-stream with count=3
    for (int i = 0; i < 3; i++) begin set_a(1, fill_v[i], 0); tick(); end
    chk("pre_rst_count", 32'(cnt_a), 32'd3);
    rst_n = 1'b0;
    #2;
    model_reset();
    check_a(); check_b();
    #2 rst_n = 1'b1;

    // Flush at count=2, hwm=3 with push and pop both offered
    for (int i = 0; i < 3; i++) begin set_a(1, fill_v[i], 0); tick(); end
    set_a(0, 8'h0, 1); tick();
    chk("pre_clr_count", 32'(cnt_a), 32'd2);
    chk("pre_clr_hwm", 32'(hwm_a), 32'd3);
    set_a(1, 8'h99, 1); clr_a = 1'b1; tick();
    clr_a = 1'b0; set_a(0, 8'h0, 0);
    chk("clr_out_data", 32'(ifa.out_data), 32'h0);
    chk("clr_hwm", 32'(hwm_a), 32'd0);

    // Steady stream: one word in flight, pointers wrap repeatedly
    for (int i = 0; i < 20; i++) begin set_a(1, 8'(i), 1); tick(); end
    chk("stream_count", 32'(cnt_a), 32'd1);
    chk("stream_hwm", 32'(hwm_a), 32'd1);
    chk("stream_last", 32'(ifa.out_data), 32'h13);
    set_a(0, 8'h0, 1); tick();

    // Randomised traffic on both configurations
    pushed_a = 0; pushed_b = 0; acc_a = 0; acc_b = 0;
    set_a(0, 8'h0, 0);
    for (int cyc = 0; cyc < 20000 && (pushed_a < 1000 || pushed_b < 1000 ||
                                      qa.size() != 0 || qb.size() != 0); cyc++) begin
      if (!ifa.in_valid || acc_a) begin
        ifa.in_valid = (pushed_a < 1000) && ($urandom_range(0, 1) == 1);
        ifa.in_data  = 8'($urandom);
      end
      if (!ifb.in_valid || acc_b) begin
        ifb.in_valid = (pushed_b < 1000) && ($urandom_range(0, 1) == 1);
        ifb.in_data  = $urandom;
      end
      ifa.out_ready = ($urandom_range(0, 1) == 1);
      ifb.out_ready = ($urandom_range(0, 1) == 1);
      tick();
    end
    chk("rand_words_a", pushed_a, 32'd1000);
    chk("rand_words_b", pushed_b, 32'd1000);
    chk("rand_empty_a", qa.size(), 32'd0);
    chk("rand_empty_b", qb.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
